alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one combinational ALU instance between two requesters.
- Round-robin arbitration at request acceptance; operands and opcode are registered.
- The ALU is driven from those registers and its result is registered.
- A single response is held on a valid/ready channel tagged with the requester id.
- Sits between the decode/execute stages and the ALU; the ALU itself stays unchanged and external.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU data width.
- OPW, 4, opcode width; must match the ALU opcode width.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_a  input  WIDTH  requester 0 first operand.
- req0_b  input  WIDTH  requester 0 second operand.
- req0_op  input  OPW  requester 0 ALU opcode.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req1_valid / req1_a / req1_b / req1_op / req1_ready  same as requester 0, for requester 1.
- alu_a  output  WIDTH  to ALU first input.
- alu_b  output  WIDTH  to ALU second input.
- alu_op  output  OPW  to ALU opcode.
- alu_result  input  WIDTH  from ALU result.
- rsp_valid  output  1  response held.
- rsp_id  output  1  requester that issued the response's operation.
- rsp_data  output  WIDTH  captured ALU result.
- rsp_zero  output  1  rsp_data == 0.
- rsp_err  output  1  opcode was not a defined ALU opcode.
- rsp_ready  input  1  consumer accepts the response.

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values: rsp_valid=0, rsp_id=0, rsp_data=0, rsp_zero=0, rsp_err=0, alu_a=0, alu_b=0, alu_op=4'b0111 (ZERO), priority pointer=0.
- Asserting reset in any state aborts the in-flight operation and returns to IDLE immediately; nothing is emitted.
- reqN_ready is combinational. It is high only in IDLE, and only for the granted requester. It never depends on rsp_ready.
- Grant rule in IDLE:
  - Only one valid: that requester is granted.
  - Both valid: the requester selected by the priority pointer is granted.
  - Neither valid: stay in IDLE.
- On a grant (valid && ready):
  - Capture a, b and op into the operand registers.
  - Capture the requester id.
  - Set the priority pointer to the other requester.
  - Go to EXEC.
- Operand registers drive alu_a/alu_b/alu_op directly. They change only on a grant.
- EXEC (1 cycle):
  - rsp_data <= alu_result; rsp_zero <= (alu_result == 0).
  - rsp_err <= opcode not in {0010 ADD, 0111 ZERO, 1010 SUB, 0110 AND, 0100 OR, 1001 XOR, 0101 NOR, 1100 NAND, 1101 PASSA}.
  - rsp_id <= captured id; rsp_valid <= 1; go to RESP.
- Erroring ops still complete normally; rsp_data is whatever the ALU returns (0 for undefined opcodes).
- RESP:
  - rsp_* outputs are held stable while rsp_valid && !rsp_ready.
  - On rsp_valid && rsp_ready: rsp_valid <= 0, go to IDLE.
  - No new grant occurs in the handshake cycle.
- Latency: grant edge to rsp_valid high = 2 clocks. Peak throughput is one operation per 3 clocks.
- Arithmetic is the ALU's own: modulo 2^WIDTH, no carry/overflow outputs. The arbiter adds no width extension.
- A requester that drops valid without a grant is not an error and loses nothing. A requester with valid held across RESP is granted on the first IDLE cycle.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1.

Test Plan:
- Single ADD, requester 0: a=5, b=7, op=0010 → req0_ready for 1 cycle; 2 clocks later rsp_valid=1, rsp_id=0, rsp_data=12, rsp_zero=0, rsp_err=0.
- SUB wrap, requester 1: a=0, b=1, op=1010 → rsp_data=32'hFFFF_FFFF, rsp_id=1; then a=3, b=3 → rsp_data=0, rsp_zero=1.
- Both requesters valid continuously for 4 operations with rsp_ready=1 → grant order 0,1,0,1; rsp_id sequence 0,1,0,1; each response 3 clocks apart.
- Backpressure: rsp_ready=0 for 5 cycles during RESP with new req1_valid pending → rsp_* stable, req1_ready=0 throughout; req1 granted on the first cycle after the handshake.
- Undefined opcode 4'b1111, a=9, b=9 → rsp_err=1, rsp_data=0, rsp_zero=1; the next legal op returns rsp_err=0.
- Reset asserted mid-EXEC → rsp_valid=0 and all outputs at reset values immediately; the aborted op is never emitted; after release the first granted op completes normally with priority starting at requester 0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Two-requester front end for one shared combinational ALU.
// Round-robin grant, registered operands, one held response.
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             req1_ready,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_err,
    input  logic             rsp_ready
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    localparam logic [OPW-1:0] OP_ADD   = OPW'(4'b0010);
    localparam logic [OPW-1:0] OP_ZERO  = OPW'(4'b0111);
    localparam logic [OPW-1:0] OP_SUB   = OPW'(4'b1010);
    localparam logic [OPW-1:0] OP_AND   = OPW'(4'b0110);
    localparam logic [OPW-1:0] OP_OR    = OPW'(4'b0100);
    localparam logic [OPW-1:0] OP_XOR   = OPW'(4'b1001);
    localparam logic [OPW-1:0] OP_NOR   = OPW'(4'b0101);
    localparam logic [OPW-1:0] OP_NAND  = OPW'(4'b1100);
    localparam logic [OPW-1:0] OP_PASSA = OPW'(4'b1101);

    state_t st;
    state_t st_nx;
    logic   ptr;
    logic   id_q;
    logic   g0;
    logic   g1;
    logic   op_bad;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) st <= IDLE;
        else       st <= st_nx;
    end

    // Next state: one cycle of EXEC, hold RESP until the consumer takes it.
    always_comb begin
        st_nx = st;
        unique case (st)
            IDLE:    if (g0 || g1) st_nx = EXEC;
            EXEC:    st_nx = RESP;
            RESP:    if (rsp_ready) st_nx = IDLE;
            default: st_nx = IDLE;
        endcase
    end

    // Grants: only in IDLE; pointer breaks the tie when both ask.
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (st == IDLE) begin
            g0 = req0_valid && (!req1_valid || !ptr);
            g1 = req1_valid && (!req0_valid || ptr);
        end
        req0_ready = g0;
        req1_ready = g1;
    end

    // Flag opcodes the ALU does not define.
    always_comb begin
        op_bad = 1'b1;
        case (alu_op)
            OP_ADD, OP_ZERO, OP_SUB,
            OP_AND, OP_OR, OP_XOR,
            OP_NOR, OP_NAND, OP_PASSA: op_bad = 1'b0;
            default:                   op_bad = 1'b1;
        endcase
    end

    // Operand capture on grant, result capture in EXEC, response release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= OP_ZERO;
            id_q      <= 1'b0;
            ptr       <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            if (g0) begin
                alu_a  <= req0_a;
                alu_b  <= req0_b;
                alu_op <= req0_op;
                id_q   <= 1'b0;
                ptr    <= 1'b1;
            end else if (g1) begin
                alu_a  <= req1_a;
                alu_b  <= req1_b;
                alu_op <= req1_op;
                id_q   <= 1'b1;
                ptr    <= 1'b0;
            end
            if (st == EXEC) begin
                rsp_data  <= alu_result;
                rsp_zero  <= (alu_result == '0);
                rsp_err   <= op_bad;
                rsp_id    <= id_q;
                rsp_valid <= 1'b1;
            end else if (st == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU.
// Every expectation is a hand-computed constant.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [3:0]  req0_op;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [3:0]  req1_op;
    logic        req1_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        rsp_valid;
    logic        rsp_id;
    logic [31:0] rsp_data;
    logic        rsp_zero;
    logic        rsp_err;
    logic        rsp_ready;

    int n_cmp = 0;
    int n_bad = 0;

    alu_share_arbiter #(.WIDTH(32), .OPW(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .req1_ready (req1_ready),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .rsp_ready  (rsp_ready)
    );

    always #5 clk = ~clk;

    // External ALU: undefined opcodes return 0.
    always_comb begin
        alu_result = 32'h0;
        case (alu_op)
            4'b0010: alu_result = alu_a + alu_b;
            4'b0111: alu_result = 32'h0;
            4'b1010: alu_result = alu_a - alu_b;
            4'b0110: alu_result = alu_a & alu_b;
            4'b0100: alu_result = alu_a | alu_b;
            4'b1001: alu_result = alu_a ^ alu_b;
            4'b0101: alu_result = ~(alu_a | alu_b);
            4'b1100: alu_result = ~(alu_a & alu_b);
            4'b1101: alu_result = alu_a;
            default: alu_result = 32'h0;
        endcase
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    // Present one op on an idle arbiter, expect it granted, wait for rsp.
    task automatic issue(input logic id, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] op);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end
        #1;
        chk("grant_rdy", {31'b0, (id ? req1_ready : req0_ready)}, 1);
        chk("other_rdy", {31'b0, (id ? req0_ready : req1_ready)}, 0);
        nxt();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk("exec_a", alu_a, a);
        chk("exec_b", alu_b, b);
        chk("exec_op", {28'b0, alu_op}, {28'b0, op});
        chk("exec_nov", {31'b0, rsp_valid}, 0);
        nxt();
        chk("rsp_valid", {31'b0, rsp_valid}, 1);
        chk("rsp_id", {31'b0, rsp_id}, {31'b0, id});
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        nxt();
        #1;
        chk("ack_clear", {31'b0, rsp_valid}, 0);
        rsp_ready = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, {31'b0, rsp_valid}, 0);
        chk({tag, "_id"}, {31'b0, rsp_id}, 0);
        chk({tag, "_data"}, rsp_data, 0);
        chk({tag, "_zero"}, {31'b0, rsp_zero}, 0);
        chk({tag, "_err"}, {31'b0, rsp_err}, 0);
        chk({tag, "_a"}, alu_a, 0);
        chk({tag, "_b"}, alu_b, 0);
        chk({tag, "_op"}, {28'b0, alu_op}, 32'h7);
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
        rsp_ready = 1'b0;
        nxt();
        nxt();
        chk_reset_vals("rst");
        reset = 1'b0;
        nxt();

        // ADD from requester 0
        issue(1'b0, 32'd5, 32'd7, 4'b0010);
        chk("add_data", rsp_data, 32'd12);
        chk("add_zero", {31'b0, rsp_zero}, 0);
        chk("add_err", {31'b0, rsp_err}, 0);
        ack();

        // SUB wrap and SUB to zero from requester 1
        issue(1'b1, 32'd0, 32'd1, 4'b1010);
        chk("sub_wrap", rsp_data, 32'hFFFF_FFFF);
        chk("sub_wrap_z", {31'b0, rsp_zero}, 0);
        ack();
        issue(1'b1, 32'd3, 32'd3, 4'b1010);
        chk("sub_zero_d", rsp_data, 32'd0);
        chk("sub_zero_z", {31'b0, rsp_zero}, 1);
        chk("sub_zero_e", {31'b0, rsp_err}, 0);
        ack();

        // Both valid continuously: grants alternate, rsp every 3 clocks
        req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd1;
        req0_op = 4'b0010;
        req1_valid = 1'b1; req1_a = 32'hF0; req1_b = 32'h0F;
        req1_op = 4'b1001;
        rsp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            chk("rr_r0", {31'b0, req0_ready},
                {31'b0, (i % 3 == 0) && ((i / 3) % 2 == 0)});
            chk("rr_r1", {31'b0, req1_ready},
                {31'b0, (i % 3 == 0) && ((i / 3) % 2 == 1)});
            chk("rr_v", {31'b0, rsp_valid}, {31'b0, i % 3 == 2});
            if (i % 3 == 2) begin
                chk("rr_id", {31'b0, rsp_id},
                    {31'b0, (i / 3) % 2 == 1});
                chk("rr_data", rsp_data,
                    ((i / 3) % 2 == 1) ? 32'hFF : 32'd11);
            end
            nxt();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b0;
        #1;
        chk("rr_end", {31'b0, rsp_valid}, 0);
        nxt();

        // Backpressure with requester 1 pending
        req0_valid = 1'b1; req0_a = 32'hFF; req0_b = 32'h0F;
        req0_op = 4'b0110;
        #1;
        chk("bp_g0", {31'b0, req0_ready}, 1);
        nxt();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 32'h1234; req1_b = 32'h0;
        req1_op = 4'b1101;
        #1;
        chk("bp_exec_r1", {31'b0, req1_ready}, 0);
        nxt();
        for (int i = 0; i < 5; i++) begin
            if (i == 4) rsp_ready = 1'b1;
            #1;
            chk("bp_v", {31'b0, rsp_valid}, 1);
            chk("bp_id", {31'b0, rsp_id}, 0);
            chk("bp_data", rsp_data, 32'h0F);
            chk("bp_r1", {31'b0, req1_ready}, 0);
            nxt();
        end
        rsp_ready = 1'b0;
        #1;
        chk("bp_after_v", {31'b0, rsp_valid}, 0);
        chk("bp_after_r1", {31'b0, req1_ready}, 1);
        nxt();
        req1_valid = 1'b0;
        #1;
        chk("bp_exec_a", alu_a, 32'h1234);
        nxt();
        chk("bp_rsp_v", {31'b0, rsp_valid}, 1);
        chk("bp_rsp_id", {31'b0, rsp_id}, 1);
        chk("bp_rsp_d", rsp_data, 32'h1234);
        ack();

        // Undefined opcode, then a legal one
        issue(1'b0, 32'd9, 32'd9, 4'b1111);
        chk("bad_err", {31'b0, rsp_err}, 1);
        chk("bad_data", rsp_data, 32'd0);
        chk("bad_zero", {31'b0, rsp_zero}, 1);
        ack();
        issue(1'b0, 32'd0, 32'd0, 4'b0101);
        chk("nor_err", {31'b0, rsp_err}, 0);
        chk("nor_data", rsp_data, 32'hFFFF_FFFF);
        chk("nor_zero", {31'b0, rsp_zero}, 0);
        ack();

        // Reset during EXEC: aborted, pointer back to requester 0
        req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd4;
        req0_op = 4'b1010;
        nxt();
        req0_valid = 1'b0;
        #1;
        chk("mid_a", alu_a, 32'd10);
        reset = 1'b1;
        #1;
        chk_reset_vals("abort");
        nxt();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("abort_quiet", {31'b0, rsp_valid}, 0);
            nxt();
        end
        req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd23;
        req0_op = 4'b0010;
        req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1;
        req1_op = 4'b0010;
        #1;
        chk("post_r0", {31'b0, req0_ready}, 1);
        chk("post_r1", {31'b0, req1_ready}, 0);
        nxt();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        nxt();
        chk("post_v", {31'b0, rsp_valid}, 1);
        chk("post_id", {31'b0, rsp_id}, 0);
        chk("post_data", rsp_data, 32'd123);
        ack();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
